// File: rtl/p16_uart_pkg.sv
// Shared types and helpers for the p16 UART receiver.
// Receiver state encoding and bit-period arithmetic.
package p16_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/p16_uart_rx_if.sv
// Byte-stream bundle between the UART receiver and its consumer.
// master = receiver side, slave = consumer side.
interface p16_uart_rx_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output data,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/p16_sync2.sv
// Two-flop synchronizer with a parameterised reset value.
// Async active-high reset.
module p16_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[0], i_d};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= ff_d;
    end
  end

  assign o_q = ff_q[1];

endmodule

// File: rtl/p16_uart_rx.sv
// 8/N/1 UART receiver with valid/ready output and error pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module p16_uart_rx
  import p16_uart_pkg::*;
#(
  parameter int CLK_FREQ = 250000,
  parameter int BAUD     = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(2 * CPB + 1);

  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic rxs;

  p16_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_in),
    .o_q   (rxs)
  );

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic active;
  logic tick;
  logic decide;
  logic sample;
  logic hshake;

`ifdef UART_RX_MAJORITY_EN
  logic s1_q, s1_d;
  logic s0_q, s0_d;
  logic pend_q, pend_d;
`endif

  always_comb begin
    active = (state_q == START) ||
             (state_q == DATA)  ||
             (state_q == STOP);
    tick   = active && (cnt_q == '0);
    hshake = valid_q && i_ready;

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one cycle after counter 0,
    // once the third sample is available.
    s1_d   = (active && cnt_q == CNT_ONE) ? rxs : s1_q;
    s0_d   = tick ? rxs : s0_q;
    pend_d = tick;
    decide = pend_q;
    sample = maj3(s1_q, s0_q, rxs);
`else
    decide = tick;
    sample = rxs;
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = hshake ? 1'b0 : valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Counter free-runs per bit so the decision
    // delay never stretches the bit period.
    if (active) begin
      cnt_d = tick ? CNT_BIT : cnt_q - CNT_ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (decide) begin
          if (sample) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
            idx_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_d[idx_q] = sample;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (decide) begin
          cnt_d = '0;
          if (sample) begin
            state_d = IDLE;
            if (!valid_q || hshake) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            state_d = WAIT_HIGH;
            ferr_d  = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s1_q    <= 1'b1;
      s0_q    <= 1'b1;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_MAJORITY_EN
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_p16_uart_rx.sv
// Directed self-checking bench for p16_uart_rx.
// 250 kHz clock, 9600 baud: 26 clocks per bit.
module tb_p16_uart_rx;
  import p16_uart_pkg::*;

  localparam int BIT = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_in = 1'b1;

  p16_uart_rx_if rx_if();

  always #5 clk = ~clk;

  p16_uart_rx #(
    .CLK_FREQ (250000),
    .BAUD     (9600)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in        (rx_in),
    .o_data      (rx_if.data),
    .o_valid     (rx_if.valid),
    .i_ready     (rx_if.ready),
    .o_frame_err (rx_if.frame_err),
    .o_overrun   (rx_if.overrun)
  );

  int vectors = 0;
  int errors  = 0;

  int vcyc   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] acc[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.valid) vcyc++;
      if (rx_if.valid && rx_if.ready) acc.push_back(rx_if.data);
      if (rx_if.frame_err) fe_cnt++;
      if (rx_if.overrun) ov_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    vcyc = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    acc.delete();
  endtask

  // Called 1 time unit after a rising edge; glitch_bit
  // flips one cycle mid-way through that data bit (99 = none).
  task automatic send_frame(
    input logic [7:0] b,
    input logic       stop_bit,
    input int         glitch_bit
  );
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < BIT; k++) begin
        rx_in = (i == glitch_bit + 1 && k == 17) ? ~fr[i] : fr[i];
        @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic logic [7:0] acc_at(input int i);
    return (acc.size() > i) ? acc[i] : 8'hxx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b1;
    rx_if.ready = 1'b0;
    tick(3);
    vectors++; if (rx_if.data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", rx_if.data); end
    vectors++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rx_if.valid); end
    vectors++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", rx_if.frame_err); end
    vectors++; if (rx_if.overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b want 0", rx_if.overrun); end
    vectors++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dut.state_q); end
    vectors++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", dut.cnt_q); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_good_frame();
    rx_if.ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1, 99);
    tick(30);
    vectors++; if (acc.size() !== 1) begin errors++; $display("FAIL good_count: got %0d want 1", acc.size()); end
    vectors++; if (acc_at(0) !== 8'hA5) begin errors++; $display("FAIL good_data: got %h want a5", acc_at(0)); end
    vectors++; if (vcyc !== 1) begin errors++; $display("FAIL good_vcyc: got %0d want 1", vcyc); end
    vectors++; if (fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL good_err: got %0d want 0", fe_cnt + ov_cnt); end
    vectors++; if (rx_if.data !== 8'hA5) begin errors++; $display("FAIL good_hold: got %h want a5", rx_if.data); end
  endtask

  task automatic test_start_glitch();
    clear_mon();
    rx_in = 1'b0;
    tick(5);
    rx_in = 1'b1;
    tick(40);
    vectors++; if (vcyc !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", vcyc); end
    vectors++; if (fe_cnt !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt); end
    vectors++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_frame_err();
    rx_if.ready = 1'b1;
    clear_mon();
    send_frame(8'h3C, 1'b0, 99);
    tick(2 * BIT);
    rx_in = 1'b1;
    tick(30);
    vectors++; if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fe_cnt); end
    vectors++; if (vcyc !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", vcyc); end
    vectors++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ferr_state: got %0d want IDLE", dut.state_q); end
    clear_mon();
    send_frame(8'h5A, 1'b1, 99);
    tick(30);
    vectors++; if (acc_at(0) !== 8'h5A) begin errors++; $display("FAIL ferr_next: got %h want 5a", acc_at(0)); end
    vectors++; if (vcyc !== 1) begin errors++; $display("FAIL ferr_next_vcyc: got %0d want 1", vcyc); end
    vectors++; if (fe_cnt !== 0) begin errors++; $display("FAIL ferr_next_ferr: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_back_to_back();
    rx_if.ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1, 99);
    send_frame(8'h22, 1'b1, 99);
    tick(30);
    vectors++; if (rx_if.data !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h want 11", rx_if.data); end
    vectors++; if (rx_if.valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_if.valid); end
    vectors++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", ov_cnt); end
    vectors++; if (fe_cnt !== 0) begin errors++; $display("FAIL ovr_ferr: got %0d want 0", fe_cnt); end
    rx_if.ready = 1'b1;
    tick(2);
    vectors++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL ovr_drop: got %b want 0", rx_if.valid); end
    vectors++; if (rx_if.data !== 8'h11) begin errors++; $display("FAIL ovr_hold: got %h want 11", rx_if.data); end
    vectors++; if (acc.size() !== 1) begin errors++; $display("FAIL ovr_acc: got %0d want 1", acc.size()); end
    clear_mon();
    send_frame(8'h33, 1'b1, 99);
    send_frame(8'h44, 1'b1, 99);
    tick(30);
    vectors++; if (acc.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", acc.size()); end
    vectors++; if (acc_at(0) !== 8'h33) begin errors++; $display("FAIL b2b_first: got %h want 33", acc_at(0)); end
    vectors++; if (acc_at(1) !== 8'h44) begin errors++; $display("FAIL b2b_second: got %h want 44", acc_at(1)); end
    vectors++; if (ov_cnt !== 0) begin errors++; $display("FAIL b2b_ovr: got %0d want 0", ov_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    rx_if.ready = 1'b1;
    clear_mon();
    rx_in = 1'b0;
    tick(BIT);
    rx_in = 1'b1;
    tick(4 * BIT + 10);
    rst = 1'b1;
    tick(2);
    vectors++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", rx_if.valid); end
    vectors++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d want IDLE", dut.state_q); end
    rst = 1'b0;
    tick(5 * BIT);
    send_frame(8'h81, 1'b1, 99);
    tick(30);
    vectors++; if (acc.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", acc.size()); end
    vectors++; if (acc_at(0) !== 8'h81) begin errors++; $display("FAIL mid_data: got %h want 81", acc_at(0)); end
    vectors++; if (fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL mid_err: got %0d want 0", fe_cnt + ov_cnt); end
  endtask

  task automatic test_mid_bit_glitch();
    logic [7:0] exp;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'h00;
`else
    exp = 8'h04;
`endif
    rx_if.ready = 1'b1;
    clear_mon();
    send_frame(8'h00, 1'b1, 2);
    tick(30);
    vectors++; if (acc.size() !== 1) begin errors++; $display("FAIL maj_count: got %0d want 1", acc.size()); end
    vectors++; if (acc_at(0) !== exp) begin errors++; $display("FAIL maj_data: got %h want %h", acc_at(0), exp); end
  endtask

  initial begin
    rx_if.ready = 1'b0;
    test_reset();
    test_good_frame();
    test_start_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_mid_bit_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
